ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester round-robin arbiter that shares one block RAM (registered-read, separate write/read address ports, `blk_select` gating) between two masters. It sits directly in front of the RAM instance. It accepts at most one transaction per cycle, drives the RAM control and address ports, and returns read data to the master that issued the read with fixed 1-cycle latency.

## Interface
- `MEM_WIDTH`, 16: data width; must match the RAM.
- `ADD_SIZE`, 10: address width; must match the RAM.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  master request; held high with its fields stable until granted.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADD_SIZE  transaction address.
- `wdata0` / `wdata1`  in  MEM_WIDTH  write data.
- `gnt0` / `gnt1`  out  1  combinational accept; the transaction retires at the edge ending this cycle.
- `rvalid0` / `rvalid1`  out  1  registered; `rdata` belongs to this master this cycle.
- `rdata`  out  MEM_WIDTH  passthrough of `ram_dout`.
- `ram_din`  out  MEM_WIDTH  to RAM `din`.
- `ram_addr_wr`, `ram_addr_rd`  out  ADD_SIZE  to RAM write/read address.
- `ram_wr_en`, `ram_rd_en`, `ram_blk_select`  out  1  to RAM enables.
- `ram_dout`  in  MEM_WIDTH  from RAM `dout`.

## Operation
- Priority state `last` (1 bit) holds the index of the most recently granted master.
  - Reset value is 1, so master 0 wins the first contention.
- Grant logic is combinational and one-hot-or-zero:
  - Single requester: that requester is granted.
  - Both requesting: grant goes to `~last`.
  - No request: no grant.
- `last` updates to the granted index on every cycle with a grant. It holds when there is no grant.
- While `rst` is high:
  - `gnt0` = `gnt1` = 0.
  - All `ram_*` enables are 0.
- Muxing from the granted master:
  - `ram_addr_wr` = `ram_addr_rd` = granted `addr`.
  - `ram_din` = granted `wdata`.
  - `ram_wr_en` = granted `we`.
  - `ram_rd_en` = granted `~we`.
  - `ram_blk_select` = `gnt0 | gnt1`.
- With no grant, the address and data outputs carry master 0's fields. This is harmless because the enables are 0.
- Each accepted read sets `rvalid<i>` for exactly the following cycle. There is no read/write overlap, since only one operation is accepted per cycle.
- Ungranted masters keep `req` asserted. The arbiter queues nothing.
- Fairness: under continuous contention, grants alternate 0,1,0,1… Each master waits at most 1 cycle.

## Timing
- Grant latency: 0 cycles. `gnt` is valid in the same cycle as `req`.
- Write: memory is updated at the edge ending the grant cycle.
- Read: grant in cycle N; RAM registers `dout` at edge N. `rvalid<i>` and `rdata` are valid throughout cycle N+1.
- Read-after-write to the same address in the next cycle returns the new data.
- Back-to-back reads by alternating masters give one `rvalid` per cycle, tagged to the correct master.
- Reset:
  - `rvalid0` = `rvalid1` = 0 and `last` = 1 in the cycle after `rst` is sampled high.
  - A read accepted in the cycle before reset asserts has its `rvalid` dropped, because reset wins.
  - The RAM's own reset clears `dout`.
- Request deasserted without a grant: no effect. A request is never partially accepted.

## Structure
- Package `ram_arb_pkg`:
  - Master index constants `M0` = 0, `M1` = 1.
  - Reset value of `last` (`LAST_RST` = `M1`).
- Sub-module `rr_arb2`:
  - Inputs: `req[1:0]`, `last`. Output: one-hot `gnt[1:0]`.
  - Purely combinational; the `last` register lives in `ram_arbiter`.
- `ram_arbiter` holds:
  - the `last` register;
  - the `rvalid` registers (a 2-bit shift from `gnt & ~we`);
  - the RAM port muxing.
- The RAM is instantiated by the parent. The bench instantiates both.

## Test plan
- Reset then idle: hold `rst` 2 cycles, no requests → all grants, enables and `rvalid` = 0; `last` = 1.
- Single write then read:
  - Master 0 writes 0xBEEF to address 0x005 → `gnt0` in the same cycle, `ram_wr_en`=1.
  - Next cycle, master 0 reads 0x005 → one cycle later `rvalid0`=1, `rdata`=0xBEEF, `rvalid1`=0.
- Contention:
  - Both masters read continuously, with 0x010=0x1111 and 0x020=0x2222 preloaded (master 0 at 0x010, master 1 at 0x020).
  - Required: grants alternate 0,1,0,1 starting with 0.
  - Required: `rvalid` alternates likewise, with `rdata` 0x1111/0x2222 in matching cycles.
- Mixed read/write collision:
  - Master 1 writes 0x00AA to 0x3FF while master 0 reads 0x3FF in the same cycle, `last`=0.
  - Required: master 1 is granted first; master 0's read is granted next cycle and returns 0x00AA.
- Reset mid-read: master 1 read granted in cycle N, `rst`=1 in cycle N+1 → `rvalid1`=0 in N+1 and N+2; after release the first contention grants master 0.
- Address wrap/extremes: write then read 0x000 and 0x3FF with data 0xFFFF and 0x0000 → exact readback, with no aliasing between the two addresses.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-master RAM arbiter: master indices and the
// reset value of the round-robin priority state.
package ram_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  // Reset to M1 so master 0 wins the first contention.
  localparam master_e LAST_RST = M1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus between two masters + block RAM (environment side) and the arbiter.
// Handshake: a master holds reqN and its fields stable until gntN is seen high
// in the same cycle; the transaction retires at that cycle's rising edge, and a
// read returns on rdata while rvalidN is high in the following cycle.
interface ram_arbiter_if #(
  parameter int MEM_WIDTH = 16,
  parameter int ADD_SIZE  = 10
);
  logic                 req0, req1;
  logic                 we0, we1;
  logic [ADD_SIZE-1:0]  addr0, addr1;
  logic [MEM_WIDTH-1:0] wdata0, wdata1;
  logic                 gnt0, gnt1;
  logic                 rvalid0, rvalid1;
  logic [MEM_WIDTH-1:0] rdata;
  logic [MEM_WIDTH-1:0] ram_din;
  logic [ADD_SIZE-1:0]  ram_addr_wr, ram_addr_rd;
  logic                 ram_wr_en, ram_rd_en, ram_blk_select;
  logic [MEM_WIDTH-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           ram_din, ram_addr_wr, ram_addr_rd, ram_wr_en, ram_rd_en, ram_blk_select
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           ram_din, ram_addr_wr, ram_addr_rd, ram_wr_en, ram_rd_en, ram_blk_select
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the priority register lives in the
// parent so this block stays stateless.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_e    last,
  output logic [1:0] gnt
);

  // Under contention the master that was not granted most recently wins.
  assign gnt[0] = req[0] & (~req[1] | (last == M1));
  assign gnt[1] = req[1] & (~req[0] | (last == M0));

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-read block RAM between two masters: one transaction per
// cycle, round-robin under contention, read data tagged back with rvalidN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_WIDTH = 16,
  parameter int ADD_SIZE  = 10
) (
  input  logic               clk,
  input  logic               rst,
  ram_arbiter_if.slave       bus,
  output logic               dbg_last
);

  master_e              last;
  logic [1:0]           req;
  logic [1:0]           gnt_raw;
  logic [1:0]           gnt;
  logic [1:0]           rd_acc;
  logic [1:0]           rvalid_q;
  logic                 sel1;
  logic                 we_sel;
  logic [ADD_SIZE-1:0]  addr_sel;
  logic [MEM_WIDTH-1:0] wdata_sel;

  assign req = {bus.req1, bus.req0};

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last),
    .gnt  (gnt_raw)
  );

  assign gnt = rst ? 2'b00 : gnt_raw;

  // With no grant the mux falls back to master 0; harmless since enables are 0.
  always_comb begin
    sel1      = gnt[1];
    we_sel    = bus.we0;
    addr_sel  = bus.addr0;
    wdata_sel = bus.wdata0;
    if (sel1) begin
      we_sel    = bus.we1;
      addr_sel  = bus.addr1;
      wdata_sel = bus.wdata1;
    end
  end

  assign rd_acc = gnt & ~{bus.we1, bus.we0};

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= LAST_RST;
      rvalid_q <= 2'b00;
    end else begin
      if (|gnt) last <= gnt[1] ? M1 : M0;
      rvalid_q <= rd_acc;
    end
  end

  assign bus.gnt0           = gnt[0];
  assign bus.gnt1           = gnt[1];
  // Reset masks a read accepted just before it, even in the cycle it would return.
  assign bus.rvalid0        = rvalid_q[0] & ~rst;
  assign bus.rvalid1        = rvalid_q[1] & ~rst;
  assign bus.rdata          = bus.ram_dout;
  assign bus.ram_din        = wdata_sel;
  assign bus.ram_addr_wr    = addr_sel;
  assign bus.ram_addr_rd    = addr_sel;
  assign bus.ram_wr_en      = (|gnt) & we_sel;
  assign bus.ram_rd_en      = (|gnt) & ~we_sel;
  assign bus.ram_blk_select = |gnt;
  assign dbg_last           = last;

endmodule

// File: tb/tb_ram_arbiter.sv
// Cycle-by-cycle vector bench for ram_arbiter with a behavioural block RAM,
// plus a hand-written reset-during-read sequence.
module tb_ram_arbiter;

  localparam int MW = 16;
  localparam int AW = 10;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic clk;
  logic rst;
  logic dbg_last;
  int   checks;
  int   errors;

  ram_arbiter_if #(.MEM_WIDTH(MW), .ADD_SIZE(AW)) bus ();

  ram_arbiter #(.MEM_WIDTH(MW), .ADD_SIZE(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .dbg_last (dbg_last)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // block RAM model: registered read, reset clears dout
  logic [MW-1:0] mem [0:(1<<AW)-1];
  logic [MW-1:0] dout;
  always @(posedge clk) begin
    if (rst) dout <= '0;
    else if (bus.ram_blk_select && bus.ram_rd_en) dout <= mem[bus.ram_addr_rd];
    if (bus.ram_blk_select && bus.ram_wr_en) mem[bus.ram_addr_wr] <= bus.ram_din;
  end
  assign bus.ram_dout = dout;

  typedef struct {
    logic          rst;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [MW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [MW-1:0] d1;
    logic          g0, g1, wr, rd;
    logic [AW-1:0] ea;
    logic [MW-1:0] ed;
    logic          v0, v1, chk;
    logic [MW-1:0] er;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst        = v.rst;
    bus.req0   = v.r0;  bus.we0 = v.w0;  bus.addr0 = v.a0;  bus.wdata0 = v.d0;
    bus.req1   = v.r1;  bus.we1 = v.w1;  bus.addr1 = v.a1;  bus.wdata1 = v.d1;
    #3;
  endtask

  function automatic vec_t idle(input logic r);
    vec_t v;
    v = '{r, L,L,10'h0,16'h0, L,L,10'h0,16'h0, L,L,L,L, 10'h0,16'h0, L,L,L,16'h0};
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // {rst, m0 req/we/addr/wdata, m1 req/we/addr/wdata, gnt0,gnt1,wr,rd, addr,din, rv0,rv1,chk,rdata}
    vecs.push_back('{H, L,L,10'h000,16'h0000, L,L,10'h000,16'h0000, L,L,L,L, 10'h000,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{H, H,L,10'h005,16'h0000, L,L,10'h000,16'h0000, L,L,L,L, 10'h000,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{L, L,L,10'h000,16'h0000, L,L,10'h000,16'h0000, L,L,L,L, 10'h000,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{L, H,H,10'h005,16'hBEEF, L,L,10'h000,16'h0000, H,L,H,L, 10'h005,16'hBEEF, L,L,L,16'h0000});
    vecs.push_back('{L, H,L,10'h005,16'h0000, L,L,10'h000,16'h0000, H,L,L,H, 10'h005,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{L, L,L,10'h000,16'h0000, L,L,10'h000,16'h0000, L,L,L,L, 10'h000,16'h0000, H,L,H,16'hBEEF});
    vecs.push_back('{L, H,H,10'h010,16'h1111, L,L,10'h000,16'h0000, H,L,H,L, 10'h010,16'h1111, L,L,L,16'h0000});
    vecs.push_back('{L, L,L,10'h000,16'h0000, H,H,10'h020,16'h2222, L,H,H,L, 10'h020,16'h2222, L,L,L,16'h0000});
    vecs.push_back('{L, H,L,10'h010,16'h0000, H,L,10'h020,16'h0000, H,L,L,H, 10'h010,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{L, H,L,10'h010,16'h0000, H,L,10'h020,16'h0000, L,H,L,H, 10'h020,16'h0000, H,L,H,16'h1111});
    vecs.push_back('{L, H,L,10'h010,16'h0000, H,L,10'h020,16'h0000, H,L,L,H, 10'h010,16'h0000, L,H,H,16'h2222});
    vecs.push_back('{L, H,L,10'h010,16'h0000, H,L,10'h020,16'h0000, L,H,L,H, 10'h020,16'h0000, H,L,H,16'h1111});
    vecs.push_back('{L, L,L,10'h000,16'h0000, L,L,10'h000,16'h0000, L,L,L,L, 10'h000,16'h0000, L,H,H,16'h2222});
    vecs.push_back('{L, H,H,10'h3FF,16'h1234, L,L,10'h000,16'h0000, H,L,H,L, 10'h3FF,16'h1234, L,L,L,16'h0000});
    vecs.push_back('{L, H,L,10'h3FF,16'h0000, H,H,10'h3FF,16'h00AA, L,H,H,L, 10'h3FF,16'h00AA, L,L,L,16'h0000});
    vecs.push_back('{L, H,L,10'h3FF,16'h0000, L,L,10'h000,16'h0000, H,L,L,H, 10'h3FF,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{L, L,L,10'h000,16'h0000, L,L,10'h000,16'h0000, L,L,L,L, 10'h000,16'h0000, H,L,H,16'h00AA});
    vecs.push_back('{L, L,L,10'h000,16'h0000, H,H,10'h000,16'hFFFF, L,H,H,L, 10'h000,16'hFFFF, L,L,L,16'h0000});
    vecs.push_back('{L, H,H,10'h3FF,16'h0000, L,L,10'h000,16'h0000, H,L,H,L, 10'h3FF,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{L, L,L,10'h000,16'h0000, H,L,10'h000,16'h0000, L,H,L,H, 10'h000,16'h0000, L,L,L,16'h0000});
    vecs.push_back('{L, H,L,10'h3FF,16'h0000, L,L,10'h000,16'h0000, H,L,L,H, 10'h3FF,16'h0000, L,H,H,16'hFFFF});
    vecs.push_back('{L, L,L,10'h000,16'h0000, L,L,10'h000,16'h0000, L,L,L,L, 10'h000,16'h0000, H,L,H,16'h0000});

    // scoreboard over the vector table
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      check($sformatf("v%0d gnt0", i), bus.gnt0, vecs[i].g0);
      check($sformatf("v%0d gnt1", i), bus.gnt1, vecs[i].g1);
      check($sformatf("v%0d wr_en", i), bus.ram_wr_en, vecs[i].wr);
      check($sformatf("v%0d rd_en", i), bus.ram_rd_en, vecs[i].rd);
      check($sformatf("v%0d blk_select", i), bus.ram_blk_select, vecs[i].g0 | vecs[i].g1);
      check($sformatf("v%0d rvalid0", i), bus.rvalid0, vecs[i].v0);
      check($sformatf("v%0d rvalid1", i), bus.rvalid1, vecs[i].v1);
      if (vecs[i].g0 || vecs[i].g1) begin
        check($sformatf("v%0d addr_wr", i), bus.ram_addr_wr, vecs[i].ea);
        check($sformatf("v%0d addr_rd", i), bus.ram_addr_rd, vecs[i].ea);
        if (vecs[i].wr) check($sformatf("v%0d din", i), bus.ram_din, vecs[i].ed);
      end
      if (vecs[i].chk) check($sformatf("v%0d rdata", i), bus.rdata, vecs[i].er);
      if (i == 2) check("last after reset", dbg_last, 1);
    end

    // reset arriving the cycle after a granted master 1 read
    begin
      vec_t v;
      v = idle(L); v.r1 = H; v.a1 = 10'h000;
      apply(v);
      check("rst seq read gnt1", bus.gnt1, 1);
      apply(idle(H));
      check("rst seq rvalid1 during rst", bus.rvalid1, 0);
      check("rst seq gnt0 during rst", bus.gnt0, 0);
      check("rst seq blk during rst", bus.ram_blk_select, 0);
      apply(idle(L));
      check("rst seq rvalid1 after rst", bus.rvalid1, 0);
      check("rst seq rvalid0 after rst", bus.rvalid0, 0);
      check("rst seq last", dbg_last, 1);
      v = idle(L); v.r0 = H; v.a0 = 10'h005; v.r1 = H; v.a1 = 10'h020;
      apply(v);
      check("rst seq first contention gnt0", bus.gnt0, 1);
      check("rst seq first contention gnt1", bus.gnt1, 0);
      apply(idle(L));
      check("rst seq rvalid0", bus.rvalid0, 1);
      check("rst seq rdata", bus.rdata, 16'hBEEF);
    end

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
